// File: rtl/systolic_input_skewer_if.sv
// Vector handshake and skewed output bus between the upstream producer, the
// systolic_input_skewer and the array DIN port.
interface systolic_input_skewer_if #(
    parameter int DATA_BW     = 8,
    parameter int MATRIX_SIZE = 128
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_last;
    logic [MATRIX_SIZE*DATA_BW-1:0] in_data;
    logic [MATRIX_SIZE*DATA_BW-1:0] dout;
    logic [MATRIX_SIZE-1:0]         lane_valid;

    modport master (
        output in_valid, in_last, in_data,
        input  in_ready, dout, lane_valid
    );

    modport slave (
        input  in_valid, in_last, in_data,
        output in_ready, dout, lane_valid
    );
endinterface

// File: rtl/systolic_input_skewer.sv
// Staggers lane j of each accepted activation vector by j cycles and zero-flushes the
// skew pipeline after the last vector of a tile. Optional macro: SKEWER_VEC_COUNT_EN.
module systolic_input_skewer #(
    parameter int DATA_BW     = 8,
    parameter int MATRIX_SIZE = 128
) (
    input  logic                    clk,
    input  logic                    rstn,
    systolic_input_skewer_if.slave  bus,
    output logic                    busy,
    output logic                    done
`ifdef SKEWER_VEC_COUNT_EN
    ,
    output logic [15:0]             vec_count
`endif
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int               CNT_W      = (MATRIX_SIZE > 2) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MATRIX_SIZE - 2);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] drain_cnt_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;

    assign accept_s     = bus.in_valid & ready_r;
    assign bus.in_ready = ready_r;
    assign busy         = busy_r;
    assign done         = done_r;

    // Tile framing: stream until the last vector, drain the skew, pulse done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_STREAM: begin
                if (accept_s) begin
                    state_nxt_s = bus.in_last ? ST_DRAIN : ST_STREAM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, drain counter and status flags registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {CNT_W{1'b0}};
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_DRAIN) && (state_nxt_s == ST_DRAIN)) begin
                drain_cnt_r <= drain_cnt_r + CNT_W'(1);
            end else begin
                drain_cnt_r <= {CNT_W{1'b0}};
            end
            ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_STREAM);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
        logic [DATA_BW-1:0] data_r [0:j];
        logic               vld_r  [0:j];

        // Lane j delay line of j+1 stages; shifts every cycle, bubbles are signed zero.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= j; s++) begin
                    data_r[s] <= {DATA_BW{1'b0}};
                    vld_r[s]  <= 1'b0;
                end
            end else begin
                data_r[0] <= accept_s ? bus.in_data[(j+1)*DATA_BW-1 -: DATA_BW] : {DATA_BW{1'b0}};
                vld_r[0]  <= accept_s;
                for (int s = 1; s <= j; s++) begin
                    data_r[s] <= data_r[s-1];
                    vld_r[s]  <= vld_r[s-1];
                end
            end
        end

        assign bus.dout[(j+1)*DATA_BW-1 -: DATA_BW] = data_r[j];
        assign bus.lane_valid[j]                   = vld_r[j];
    end

`ifdef SKEWER_VEC_COUNT_EN
    logic [15:0] vec_count_r;

    // Saturating per-tile vector count, held through done and cleared after it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_count_r <= 16'h0000;
        end else if (state_r == ST_DONE) begin
            vec_count_r <= 16'h0000;
        end else if (accept_s && (vec_count_r != 16'hFFFF)) begin
            vec_count_r <= vec_count_r + 16'h0001;
        end else begin
            vec_count_r <= vec_count_r;
        end
    end

    assign vec_count = vec_count_r;
`endif
endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed self-checking bench for systolic_input_skewer with MATRIX_SIZE=4, DATA_BW=8.
module tb_systolic_input_skewer;
    localparam int DW = 8;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rstn;
    logic busy;
    logic done;
`ifdef SKEWER_VEC_COUNT_EN
    logic [15:0] vec_count;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    systolic_input_skewer_if #(.DATA_BW(DW), .MATRIX_SIZE(MS)) bus ();

    systolic_input_skewer #(.DATA_BW(DW), .MATRIX_SIZE(MS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy),
        .done (done)
`ifdef SKEWER_VEC_COUNT_EN
        ,
        .vec_count (vec_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            n_checks++;
            if ({bus.dout, bus.lane_valid, bus.in_ready, busy, done} !== {32'h0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset t=%0d: dout=%h lv=%b rdy=%b busy=%b done=%b, want 0/0/1/0/0",
                         t, bus.dout, bus.lane_valid, bus.in_ready, busy, done);
            end
        end
    endtask

    // One-vector tile with in_last; lane j shows its byte only in cycle t==j after accept.
    task automatic test_single(input logic [31:0] vec, input string tag);
        logic [7:0] exp_d;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: got %b want 1", tag, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = vec;
        step();
        idle_inputs();
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < MS; j++) begin
                exp_d = (t == j) ? vec[j*DW +: DW] : 8'h00;
                n_checks++;
                if (bus.dout[j*DW +: DW] !== exp_d || bus.lane_valid[j] !== (t == j)) begin
                    n_fail++;
                    $display("FAIL %s lane%0d t=%0d: got %h/%b want %h/%b", tag, j, t,
                             bus.dout[j*DW +: DW], bus.lane_valid[j], exp_d, (t == j));
                end
            end
            n_checks++;
            if ({done, bus.in_ready, busy} !== {(t == 3), (t >= 4), (t <= 3)}) begin
                n_fail++;
                $display("FAIL %s status t=%0d: done/rdy/busy=%b%b%b want %b%b%b", tag, t,
                         done, bus.in_ready, busy, (t == 3), (t >= 4), (t <= 3));
            end
            step();
        end
    endtask

    // Three-entry tile; vals/vld describe what is presented at edges 0,1,2 (edge 2 last).
    task automatic run_tile(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                            input logic [2:0] vld, input string tag);
        logic [7:0] vals [0:2];
        logic [7:0] exp_d;
        logic       exp_v;
        int         i;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        bus.in_valid = vld[0];
        bus.in_last  = 1'b0;
        bus.in_data  = {4{v0}};
        step();
        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < MS; j++) begin
                i = t - j;
                exp_v = (i >= 0 && i < 3) ? vld[i] : 1'b0;
                exp_d = exp_v ? vals[i] : 8'h00;
                n_checks++;
                if (bus.dout[j*DW +: DW] !== exp_d || bus.lane_valid[j] !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s lane%0d t=%0d: got %h/%b want %h/%b", tag, j, t,
                             bus.dout[j*DW +: DW], bus.lane_valid[j], exp_d, exp_v);
                end
            end
            n_checks++;
            if ({done, bus.in_ready} !== {(t == 5), (t < 2 || t >= 6)}) begin
                n_fail++;
                $display("FAIL %s status t=%0d: done/rdy=%b%b want %b%b", tag, t,
                         done, bus.in_ready, (t == 5), (t < 2 || t >= 6));
            end
`ifdef SKEWER_VEC_COUNT_EN
            if (t == 5) begin
                n_checks++;
                if (vec_count !== {13'h0, 3'(vld[0] + vld[1] + vld[2])}) begin
                    n_fail++;
                    $display("FAIL %s vec_count: got %0d want %0d", tag, vec_count,
                             vld[0] + vld[1] + vld[2]);
                end
            end
`endif
            if (t + 1 < 3) begin
                bus.in_valid = vld[t+1];
                bus.in_last  = (t + 1 == 2);
                bus.in_data  = {4{vals[t+1]}};
            end else begin
                idle_inputs();
            end
            step();
        end
    endtask

    task automatic test_full_rate();
        run_tile(8'h10, 8'h20, 8'h30, 3'b111, "full_rate");
    endtask

    task automatic test_bubble();
        run_tile(8'hAA, 8'h55, 8'hBB, 3'b101, "bubble");
    endtask

    task automatic test_signed();
        test_single(32'hFF80FF80, "signed_a");
        test_single(32'h80FF80FF, "signed_b");
    endtask

    task automatic test_reset_mid_tile();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = 32'h11223344;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (busy !== 1'b1 || bus.lane_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL midrst_pre: busy=%b lv=%b want 1/0010", busy, bus.lane_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.dout, bus.lane_valid, busy, done, bus.in_ready} !== {32'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_now: dout=%h lv=%b busy=%b done=%b rdy=%b want 0/0/0/0/1",
                     bus.dout, bus.lane_valid, busy, done, bus.in_ready);
        end
        for (int t = 0; t < 6; t++) begin
            if (t == 2) rstn = 1'b1;
            step();
            n_checks++;
            if ({done, busy, bus.lane_valid} !== {1'b0, 1'b0, 4'h0}) begin
                n_fail++;
                $display("FAIL midrst_after t=%0d: done=%b busy=%b lv=%b want 0/0/0",
                         t, done, busy, bus.lane_valid);
            end
        end
        test_single(32'h04030201, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single(32'h04030201, "single");
        test_full_rate();
        test_bubble();
        test_signed();
        test_reset_mid_tile();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
